// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: redirect flush with optional IF/ID flush hold,
// multi-cycle load-use stall sequencing and a whole-pipeline data-memory freeze.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_STAGES = 2,
  parameter int FLUSH_HOLD   = 0,
  parameter int LU_STALL     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    is_control_hazard,
  input  logic                    mem_busy,
  input  logic [REG_ADDR_W-1:0]   id_rs1,
  input  logic [REG_ADDR_W-1:0]   id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [REG_ADDR_W-1:0]   ex_rd,
  input  logic                    ex_mem_read,
  output logic                    stall_pc,
  output logic                    stall_if_id,
  output logic                    stall_id_ex,
  output logic                    stall_ex_mem,
  output logic [FLUSH_STAGES-1:0] flush_vec,
  output logic                    bubble_id_ex,
  output logic [1:0]              hz_state
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_FL  = 2'd2
  } hz_state_t;

  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD);
  localparam logic [2:0] LU_INIT   = 3'(LU_STALL - 1);

  hz_state_t  state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       lu;
  logic       flush_all;
  logic       flush_hold;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) ||
               (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    bubble_id_ex = 1'b0;
    flush_all    = 1'b0;
    flush_hold   = 1'b0;
    hz_state     = state_reg;
    if (rst) begin
      state_next = ST_RUN;
      cnt_next   = 3'd0;
      hz_state   = 2'd0;
    end else if (mem_busy) begin
      // Freeze everything; a redirect seen now re-asserts once memory is ready.
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
    end else if (is_control_hazard) begin
      flush_all = 1'b1;
      if (FLUSH_HOLD > 0) begin
        state_next = ST_FL;
        cnt_next   = HOLD_INIT;
      end else begin
        state_next = ST_RUN;
        cnt_next   = 3'd0;
      end
    end else begin
      case (state_reg)
        ST_LU: begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          if (cnt_reg <= 3'd1) begin
            state_next = ST_RUN;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = cnt_reg - 3'd1;
          end
        end
        ST_FL: begin
          flush_hold = 1'b1;
          if (cnt_reg <= 3'd1) begin
            state_next = ST_RUN;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = cnt_reg - 3'd1;
          end
        end
        default: begin
          if (lu) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            if (LU_STALL > 1) begin
              state_next = ST_LU;
              cnt_next   = LU_INIT;
            end
          end
        end
      endcase
    end
  end

  // Only the IF/ID flush persists through the hold window.
  for (genvar gi = 0; gi < FLUSH_STAGES; gi++) begin : g_flush
    if (gi == 0) begin : g_ifid
      assign flush_vec[gi] = flush_all | flush_hold;
    end else begin : g_rest
      assign flush_vec[gi] = flush_all;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with LU_STALL=2, FLUSH_HOLD=2, FLUSH_STAGES=2:
// a cycle-by-cycle vector table plus hand-written freeze/reset sequences.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       is_control_hazard;
  logic       mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic [1:0] flush_vec;
  logic       bubble_id_ex;
  logic [1:0] hz_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REG_ADDR_W  (5),
    .FLUSH_STAGES(2),
    .FLUSH_HOLD  (2),
    .LU_STALL    (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .is_control_hazard(is_control_hazard),
    .mem_busy         (mem_busy),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .ex_rd            (ex_rd),
    .ex_mem_read      (ex_mem_read),
    .stall_pc         (stall_pc),
    .stall_if_id      (stall_if_id),
    .stall_id_ex      (stall_id_ex),
    .stall_ex_mem     (stall_ex_mem),
    .flush_vec        (flush_vec),
    .bubble_id_ex     (bubble_id_ex),
    .hz_state         (hz_state)
  );

  typedef struct {
    string      name;
    logic       rst, ch, mb, mr, u1, u2;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] stalls;  // {pc, if_id, id_ex, ex_mem}
    logic [1:0] fl;
    logic       bub;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic ch, logic mb, logic mr,
                              logic u1, logic u2, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [3:0] stalls, logic [1:0] fl,
                              logic bub, logic [1:0] st);
    vec_t v;
    v.name = name; v.rst = r; v.ch = ch; v.mb = mb; v.mr = mr; v.u1 = u1; v.u2 = u2;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.stalls = stalls; v.fl = fl; v.bub = bub; v.st = st;
    return v;
  endfunction

  // Shorthands: idle cycle and a rs1 load-use hazard on x5.
  function automatic vec_t idle(string n, logic [3:0] s, logic [1:0] f, logic b, logic [1:0] st);
    return mk(n, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, s, f, b, st);
  endfunction
  function automatic vec_t luv(string n, logic ch, logic [3:0] s, logic [1:0] f, logic b, logic [1:0] st);
    return mk(n, 0, ch, 0, 1, 1, 0, 5'd5, 5'd0, 5'd5, s, f, b, st);
  endfunction

  task automatic apply(input vec_t v);
    logic [8:0] act, exp;
    @(negedge clk);
    rst = v.rst; is_control_hazard = v.ch; mem_busy = v.mb; ex_mem_read = v.mr;
    id_rs1_used = v.u1; id_rs2_used = v.u2; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
    #1;
    act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_vec, bubble_id_ex, hz_state};
    exp = {v.stalls, v.fl, v.bub, v.st};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got stalls=%b flush=%b bubble=%b state=%0d, expected stalls=%b flush=%b bubble=%b state=%0d",
               v.name, act[8:5], act[4:3], act[2], act[1:0], exp[8:5], exp[4:3], exp[2], exp[1:0]);
    end else begin
      $display("[TB] %s: stalls=%b flush=%b bubble=%b state=%0d ok",
               v.name, act[8:5], act[4:3], act[2], act[1:0]);
    end
  endtask

  initial begin
    rst = 1'b1; is_control_hazard = 1'b0; mem_busy = 1'b0; ex_mem_read = 1'b0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;

    vecs.push_back(mk("reset_all_high_0", 1, 1, 1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("reset_all_high_1", 1, 1, 1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(idle("idle_after_reset_0", 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(idle("idle_after_reset_1", 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(luv("lu_rs1_cycle1", 0, 4'b1100, 2'b00, 1, 2'd0));
    vecs.push_back(idle("lu_rs1_cycle2", 4'b1100, 2'b00, 1, 2'd1));
    vecs.push_back(idle("lu_rs1_done", 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("lu_x0_ignored", 0, 0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("lu_rs2_cycle1", 0, 0, 0, 1, 1, 1, 5'd3, 5'd7, 5'd7, 4'b1100, 2'b00, 1, 2'd0));
    vecs.push_back(idle("lu_rs2_cycle2", 4'b1100, 2'b00, 1, 2'd1));
    vecs.push_back(mk("lu_rs1_unused", 0, 0, 0, 1, 0, 0, 5'd9, 5'd9, 5'd9, 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("lu_rd_mismatch", 0, 0, 0, 1, 1, 1, 5'd6, 5'd2, 5'd4, 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("not_a_load", 0, 0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8, 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("redirect", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b11, 0, 2'd0));
    vecs.push_back(idle("hold_1", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("hold_2", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("hold_done", 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(luv("redirect_with_lu", 1, 4'b0000, 2'b11, 0, 2'd0));
    vecs.push_back(luv("hold_ignores_lu", 0, 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("hold_2b", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("hold_done_b", 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(luv("lu_before_abort", 0, 4'b1100, 2'b00, 1, 2'd0));
    vecs.push_back(mk("redirect_aborts_lu", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b11, 0, 2'd1));
    vecs.push_back(idle("abort_hold_1", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("abort_hold_2", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("abort_done", 4'b0000, 2'b00, 0, 2'd0));
    vecs.push_back(mk("redirect_c", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b11, 0, 2'd0));
    vecs.push_back(idle("hold_c1", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(mk("redirect_in_hold", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b11, 0, 2'd2));
    vecs.push_back(idle("reload_hold_1", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("reload_hold_2", 4'b0000, 2'b01, 0, 2'd2));
    vecs.push_back(idle("reload_done", 4'b0000, 2'b00, 0, 2'd0));

    foreach (vecs[i]) apply(vecs[i]);

    // mem_busy freeze in the middle of a load-use stall
    apply(luv("mb_lu_cycle1", 0, 4'b1100, 2'b00, 1, 2'd0));
    apply(mk("mb_freeze_1", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 2'b00, 0, 2'd1));
    apply(mk("mb_freeze_2", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 2'b00, 0, 2'd1));
    apply(mk("mb_freeze_ch", 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 2'b00, 0, 2'd1));
    apply(idle("mb_lu_resume", 4'b1100, 2'b00, 1, 2'd1));
    apply(idle("mb_lu_done", 4'b0000, 2'b00, 0, 2'd0));

    // redirect swallowed by mem_busy in RUN, and freeze during flush hold
    apply(mk("mb_ch_run", 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 2'b00, 0, 2'd0));
    apply(idle("mb_ch_run_after", 4'b0000, 2'b00, 0, 2'd0));
    apply(mk("redirect_d", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b11, 0, 2'd0));
    apply(mk("mb_in_hold", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b1111, 2'b00, 0, 2'd2));
    apply(idle("hold_d1", 4'b0000, 2'b01, 0, 2'd2));
    apply(idle("hold_d2", 4'b0000, 2'b01, 0, 2'd2));
    apply(idle("hold_d_done", 4'b0000, 2'b00, 0, 2'd0));

    // reset in the middle of a flush hold and of a load-use stall
    apply(mk("redirect_e", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b11, 0, 2'd0));
    apply(mk("rst_in_hold", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 0, 2'd0));
    apply(idle("after_rst_hold", 4'b0000, 2'b00, 0, 2'd0));
    apply(luv("lu_before_rst", 0, 4'b1100, 2'b00, 1, 2'd0));
    apply(mk("rst_in_lu", 1, 0, 0, 1, 1, 0, 5'd5, 5'd0, 5'd5, 4'b0000, 2'b00, 0, 2'd0));
    apply(idle("after_rst_lu", 4'b0000, 2'b00, 0, 2'd0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage RISC-V core.
- Extends the flush-only control-hazard logic with:
  - a configurable flush depth and a post-redirect flush hold for multi-cycle instruction fetch;
  - a load-use stall sequencer with a configurable stall length;
  - a data-memory busy freeze.
- Sits beside the pipeline registers and drives their stall/flush pins.

Parameters:
- REG_ADDR_W, 5: register index width.
- FLUSH_STAGES, 2: number of front pipeline registers flushed on redirect. bit0=IF/ID, bit1=ID/EX, up to 3 (EX/MEM).
- FLUSH_HOLD, 0: extra cycles flush_vec[0] stays high after a redirect, covering IMEM latency. Range 0..7.
- LU_STALL, 1: stall cycles inserted per load-use hazard. Range 1..7.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- is_control_hazard  in  1  taken branch/jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipeline
- id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
- id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_W  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- stall_id_ex  out  1  hold ID/EX (mem_busy only)
- stall_ex_mem  out  1  hold EX/MEM (mem_busy only)
- flush_vec  out  FLUSH_STAGES  per-register flush, bit0=IF/ID
- bubble_id_ex  out  1  insert NOP into ID/EX (load-use)
- hz_state  out  2  FSM state for debug/trace: 0 RUN, 1 LU_STALL, 2 FL_HOLD

Behaviour:
- Reset: all outputs 0, FSM=RUN, counter=0. rst overrides every input in that cycle, including combinational paths.
- Load-use detect (combinational):
  - lu = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Register x0 never triggers.
- Priority per cycle: rst > mem_busy > is_control_hazard > FSM hold state > lu.
- mem_busy:
  - stall_pc, stall_if_id, stall_id_ex, stall_ex_mem = 1; flush_vec=0; bubble_id_ex=0.
  - FSM state and counter frozen.
  - A control hazard asserted during mem_busy is ignored; the branch stays in EX and re-asserts after the freeze.
- Redirect (is_control_hazard & !mem_busy):
  - flush_vec = all ones in the same cycle (zero latency); stalls=0; bubble=0.
  - Any LU_STALL in progress is aborted.
  - Next state: FL_HOLD with counter=FLUSH_HOLD if FLUSH_HOLD>0, else RUN.
- RUN, lu & !mem_busy & !redirect:
  - stall_pc=stall_if_id=1, bubble_id_ex=1 in the same cycle.
  - If LU_STALL>1: go to LU_STALL with counter=LU_STALL-1. Otherwise stay in RUN; the next cycle re-evaluates lu, which is now clear because the load has moved on.
- LU_STALL:
  - stall_pc=stall_if_id=1, bubble_id_ex=1.
  - Counter decrements each cycle; when it reaches 1, the next state is RUN.
  - lu is not re-evaluated while in this state.
- FL_HOLD:
  - flush_vec[0]=1, other bits 0; no stalls.
  - Counter decrements; at 1, next state is RUN.
  - A new redirect here restarts the hold (counter reload).
  - lu is ignored while in FL_HOLD (the ID slot is being flushed).
- Simultaneous redirect + lu: redirect wins; no bubble, no stall.
- Counter width is 3 bits; it never wraps. Values of 0 are handled as parameter-legal no-ops (the FSM never enters a state with counter 0).
- Reset mid-stall or mid-hold: the next cycle is RUN with all outputs 0.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs high -> all outputs 0, hz_state=0. After release with no hazards -> outputs stay 0.
- Load-use, LU_STALL=2:
  - ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> stall_pc/stall_if_id/bubble_id_ex high for exactly 2 cycles, hz_state 0->1->0.
  - Same with ex_rd=0 -> no stall.
- Redirect, FLUSH_STAGES=2, FLUSH_HOLD=2: pulse is_control_hazard for 1 cycle -> flush_vec=2'b11 that cycle, then 2'b01 for 2 cycles, then 0. hz_state=2 during the hold.
- Redirect during load-use: is_control_hazard and lu asserted together -> flush_vec=2'b11, bubble_id_ex=0, stall_pc=0.
- Redirect during LU_STALL: asserted in the 2nd stall cycle -> the stall aborts immediately.
- mem_busy freeze:
  - mem_busy=1 for 3 cycles during LU_STALL (counter=1) -> all four stalls high, flush 0. On release, 1 remaining stall cycle completes.
  - is_control_hazard during mem_busy -> flush_vec stays 0.
- Reset mid-operation: rst during FL_HOLD -> next cycle flush_vec=0, hz_state=0.
